coder_move_ctrl: RTL and testbench



---
 rtl/coder_move_ctrl.sv | 161 ++++++++++++++++
 tb/tb_coder_move_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/coder_move_ctrl.sv
// Closed-loop move sequencer driving motor enable/dir/speed from target vs encoder count.
// Optional overall move timeout enabled by defining CODER_MOVE_TMO_EN.
module coder_move_ctrl #(
    parameter int          CLK_DIV     = 80,
    parameter logic [15:0] SLOW_WIN    = 16'd200,
    parameter logic [15:0] TOL         = 16'd2,
    parameter logic [15:0] SETTLE_US   = 16'd1000,
    parameter logic [15:0] STALL_US    = 16'd20000,
    parameter logic [15:0] MOVE_TMO_MS = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] target,
    input  logic [15:0] pco,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mot_en,
    output logic        mot_dir,
    output logic        mot_fast,
    output logic [15:0] pos_err
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL, S_FAST, S_SLOW, S_SETTLE, S_DONE, S_FAULT
    } state_t;

    state_t             state, state_n;
    logic [PW-1:0]      presc;
    logic               tick;
    logic [15:0]        target_reg, pco_q, cnt, abs_err;
    logic signed [15:0] err;
    logic               err_pos, pos_q;
    logic [1:0]         code_q, code_n;
    logic               accept, driving, stall, tmo;

    assign tick    = (presc == PW'(CLK_DIV - 1));
    assign err     = signed'(target_reg - pco);
    assign err_pos = (err > 16'sd0);
    assign driving = (state == S_FAST) || (state == S_SLOW);
    assign busy    = driving || (state == S_EVAL) || (state == S_SETTLE);
    assign accept  = start && !busy;
    assign stall   = driving && (cnt >= STALL_US);

    // 0x8000 has no positive counterpart, so clamp it
    always_comb begin
        abs_err = err;
        if (err[15])
            abs_err = (err == 16'sh8000) ? 16'h7FFF : 16'(-err);
    end

    assign mot_en     = driving;
    assign mot_fast   = (state == S_FAST);
    assign mot_dir    = driving && err_pos;
    assign done       = (state == S_DONE);
    assign fault      = (state == S_FAULT);
    assign fault_code = code_q;

`ifdef CODER_MOVE_TMO_EN
    logic [9:0]  us_cnt;
    logic [15:0] ms_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            us_cnt <= '0;
            ms_cnt <= '0;
        end else if (accept) begin
            us_cnt <= '0;
            ms_cnt <= '0;
        end else if (busy && tick) begin
            if (us_cnt == 10'd999) begin
                us_cnt <= '0;
                ms_cnt <= ms_cnt + 16'd1;
            end else begin
                us_cnt <= us_cnt + 10'd1;
            end
        end
    end

    assign tmo = busy && (ms_cnt >= MOVE_TMO_MS);
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^MOVE_TMO_MS;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        code_n  = 2'b00;
        unique case (state)
            S_IDLE:   if (start) state_n = S_EVAL;
            S_EVAL: begin
                if (abs_err > SLOW_WIN)  state_n = S_FAST;
                else if (abs_err > TOL)  state_n = S_SLOW;
                else                     state_n = S_SETTLE;
            end
            S_FAST: begin
                if (abs_err <= SLOW_WIN || err_pos != pos_q)
                    state_n = S_SLOW;
            end
            S_SLOW:   if (abs_err <= TOL) state_n = S_SETTLE;
            S_SETTLE: begin
                if (abs_err > TOL)           state_n = S_SLOW;
                else if (cnt >= SETTLE_US)   state_n = S_DONE;
            end
            S_DONE:   state_n = start ? S_EVAL : S_IDLE;
            S_FAULT:  if (start) state_n = S_EVAL;
            default:  state_n = S_IDLE;
        endcase
        if (busy) begin
            if (abort) begin
                state_n = S_FAULT;
                code_n  = 2'b10;
            end else if (tmo) begin
                state_n = S_FAULT;
                code_n  = 2'b11;
            end else if (stall) begin
                state_n = S_FAULT;
                code_n  = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            target_reg <= '0;
            pco_q      <= '0;
            pos_q      <= 1'b0;
            pos_err    <= '0;
            code_q     <= 2'b00;
            cnt        <= '0;
        end else begin
            state   <= state_n;
            presc   <= tick ? '0 : presc + PW'(1);
            pco_q   <= pco;
            pos_q   <= err_pos;
            pos_err <= err;
            if (accept) begin
                target_reg <= target;
                code_q     <= 2'b00;
            end else if (state_n == S_FAULT && state != S_FAULT) begin
                code_q <= code_n;
            end
            // shared settle/stall counter; any state change restarts it
            if (state_n != state)
                cnt <= '0;
            else if (driving && pco != pco_q)
                cnt <= '0;
            else if (tick && (driving || state == S_SETTLE))
                cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_coder_move_ctrl.sv
// Directed bench for coder_move_ctrl with shortened time constants.
// Timeout expectations follow CODER_MOVE_TMO_EN.
module tb_coder_move_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] target, pco;
    logic        busy, done, fault, mot_en, mot_dir, mot_fast;
    logic [1:0]  fault_code;
    logic [15:0] pos_err;

    int n_chk  = 0;
    int n_pass = 0;
    int ncyc;
    bit seen;

    coder_move_ctrl #(
        .CLK_DIV(4), .SLOW_WIN(16'd200), .TOL(16'd2),
        .SETTLE_US(16'd10), .STALL_US(16'd50), .MOVE_TMO_MS(16'd2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .target(target), .pco(pco), .busy(busy), .done(done),
        .fault(fault), .fault_code(fault_code), .mot_en(mot_en),
        .mot_dir(mot_dir), .mot_fast(mot_fast), .pos_err(pos_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_done(input int limit, output int n, output bit s);
        n = 0;
        s = 1'b0;
        while (n < limit && !s) begin
            step(1);
            n++;
            if (done) s = 1'b1;
        end
    endtask

    task automatic kick(input logic [15:0] t);
        target = t;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        target = '0; pco = '0;
        step(2);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_mot_en", mot_en, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_pos_err", pos_err, 0);
        check("rst_done", done, 0);

        // basic move 0 -> 1000
        kick(16'd1000);
        check("t1_busy", busy, 1);
        check("t1_en_early", mot_en, 0);
        step(1);
        check("t1_en", mot_en, 1);
        check("t1_fast", mot_fast, 1);
        check("t1_dir", mot_dir, 1);
        check("t1_pos_err", pos_err, 16'd1000);
        pco = 16'd799; step(2);
        check("t1_fast_799", mot_fast, 1);
        pco = 16'd800; step(1);
        check("t1_slow_800", mot_fast, 0);
        check("t1_en_800", mot_en, 1);
        pco = 16'd997; step(1);
        check("t1_en_997", mot_en, 1);
        pco = 16'd998; step(1);
        check("t1_en_998", mot_en, 0);
        check("t1_busy_settle", busy, 1);
        wait_done(200, ncyc, seen);
        check("t1_done", seen, 1);
        check("t1_settle_len", (ncyc >= 36 && ncyc <= 44), 1);
        check("t1_busy_done", busy, 0);
        check("t1_fault_done", fault, 0);
        step(1);
        check("t1_done_pulse", done, 0);

        // shortest path across the wrap
        pco = 16'hFFF0;
        kick(16'h0010);
        step(1);
        check("t2_pos_err", pos_err, 16'd32);
        check("t2_slow", mot_fast, 0);
        check("t2_en", mot_en, 1);
        check("t2_dir", mot_dir, 1);
        pco = 16'h000F; step(1);
        check("t2_settle", mot_en, 0);
        wait_done(200, ncyc, seen);
        check("t2_done", seen, 1);

        // stall with frozen count
        pco = 16'd0;
        kick(16'd500);
        step(1);
        check("t3_fast", mot_fast, 1);
        ncyc = 0;
        while (ncyc < 400 && !fault) begin
            step(1);
            ncyc++;
        end
        check("t3_fault", fault, 1);
        check("t3_code", fault_code, 2'b01);
        check("t3_en", mot_en, 0);
        check("t3_busy", busy, 0);
        check("t3_stall_len", (ncyc >= 190 && ncyc <= 210), 1);
        kick(16'd0);
        check("t3_clr_fault", fault, 0);
        check("t3_clr_code", fault_code, 0);
        wait_done(200, ncyc, seen);
        check("t3_done", seen, 1);

        // disturbance during settle
        pco = 16'd300;
        kick(16'd300);
        step(1);
        check("t4_settle", mot_en, 0);
        check("t4_busy", busy, 1);
        step(5);
        pco = 16'd310; step(1);
        check("t4_en", mot_en, 1);
        check("t4_dir", mot_dir, 0);
        check("t4_slow", mot_fast, 0);
        pco = 16'd300; step(1);
        check("t4_resettle", mot_en, 0);
        wait_done(200, ncyc, seen);
        check("t4_done", seen, 1);
        check("t4_restart_len", (ncyc >= 36), 1);

        // abort and collisions
        pco = 16'd0;
        kick(16'd1000);
        step(1);
        abort = 1'b1; step(1); abort = 1'b0;
        check("t5_abort_en", mot_en, 0);
        check("t5_abort_code", fault_code, 2'b10);
        check("t5_abort_fault", fault, 1);
        kick(16'd1000);
        check("t5_restart", fault, 0);
        step(1);
        start = 1'b1; abort = 1'b1; step(1);
        start = 1'b0; abort = 1'b0;
        check("t5_coll_fault", fault, 1);
        check("t5_coll_code", fault_code, 2'b10);
        kick(16'd1000);
        step(1);
        kick(16'd50);
        step(1);
        check("t5_ign_pos_err", pos_err, 16'd1000);
        check("t5_ign_busy", busy, 1);
        check("t5_ign_fast", mot_fast, 1);
        abort = 1'b1; step(1); abort = 1'b0;
        pco = 16'd5;
        target = 16'd5; start = 1'b1; abort = 1'b1; step(1);
        start = 1'b0; abort = 1'b0;
        check("t5_idle_coll_busy", busy, 1);
        check("t5_idle_coll_fault", fault, 0);
        check("t5_idle_coll_code", fault_code, 0);
        wait_done(200, ncyc, seen);
        check("t5_done", seen, 1);

        // long move that never arrives
        pco = 16'd0;
        kick(16'd1000);
        ncyc = 0;
        while (ncyc < 9000 && !fault) begin
            step(1);
            ncyc++;
            if (ncyc % 40 == 0) pco = pco ^ 16'd1;
        end
`ifdef CODER_MOVE_TMO_EN
        check("t6_tmo_fault", fault, 1);
        check("t6_tmo_code", fault_code, 2'b11);
        check("t6_tmo_len", (ncyc >= 7990 && ncyc <= 8020), 1);
`else
        check("t6_no_fault", fault, 0);
        check("t6_still_busy", busy, 1);
        check("t6_code", fault_code, 0);
`endif
        abort = 1'b1; step(1); abort = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
